// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction-fetch front end with a DEPTH-entry prefetch
// FIFO between the instruction memory port and the IF/ID boundary.
// Keeps fetching sequentially while decode stalls, absorbs bus_stall and
// flushes on an EXE redirect.
// Optional build macro: IF_PREFETCH_BYPASS_EN (zero-latency empty-FIFO bypass).
module if_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            im_addr,
    output logic                       im_read_mem,
    input  logic [XLEN-1:0]            im_dataout,
    input  logic                       bus_stall,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_instr,
    output logic [XLEN-1:0]            id_pc,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic fifo_valid;

    // Request, handshake and head-of-queue outputs; all forced low during reset
    always_comb begin
        im_addr     = fetch_pc_q;
        im_read_mem = !rst && !redirect_valid && (count_q < DEPTH_C);
        accept      = im_read_mem && !bus_stall;
        fifo_valid  = !rst && (count_q != '0);
        fifo_count  = rst ? '0 : count_q;
        pop         = fifo_valid && id_ready && !redirect_valid;
`ifdef IF_PREFETCH_BYPASS_EN
        // Empty FIFO: present the incoming word directly; it is stored only
        // when decode does not take it this cycle.
        if (!fifo_valid && accept) begin
            id_valid = 1'b1;
            id_instr = im_dataout;
            id_pc    = fetch_pc_q;
            push     = !id_ready;
        end else begin
            id_valid = fifo_valid;
            id_instr = fifo_valid ? instr_mem[rd_ptr_q] : '0;
            id_pc    = fifo_valid ? pc_mem[rd_ptr_q] : '0;
            push     = accept;
        end
`else
        id_valid = fifo_valid;
        id_instr = fifo_valid ? instr_mem[rd_ptr_q] : '0;
        id_pc    = fifo_valid ? pc_mem[rd_ptr_q] : '0;
        push     = accept;
`endif
    end

    // Next-state for fetch pc, pointers and occupancy; redirect wins over all
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)   wr_ptr_d   = wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_d   = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only visible through count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= im_dataout;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit (default build, no bypass).
// A reference model of fetch pc and FIFO contents predicts every output;
// accepted fetch pcs are queued and popped when decode consumes them.
module tb_if_prefetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_addr;
    logic        im_read_mem;
    logic [31:0] im_dataout;
    logic        bus_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    // Instruction memory: word distinguishable from its address
    assign im_dataout = ~im_addr;

    if_prefetch_unit #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .im_addr       (im_addr),
        .im_read_mem   (im_read_mem),
        .im_dataout    (im_dataout),
        .bus_stall     (bus_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .fifo_count    (fifo_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    string       phase    = "init";
    logic [31:0] m_pc;
    logic [31:0] mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    endtask

    // One clock cycle: drive inputs at negedge, check settled outputs, advance model
    task automatic cycle(input logic rdy, input logic stall, input logic redir,
                         input logic [31:0] rpc);
        logic exp_req, acc, pp;
        id_ready       = rdy;
        bus_stall      = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #2;
        exp_req = !redir && (mq.size() < DEPTH);
        check("im_read_mem", im_read_mem, exp_req);
        check("im_addr", im_addr, m_pc);
        check("fifo_count", fifo_count, mq.size());
        check("id_valid", id_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("id_pc", id_pc, mq[0]);
            check("id_instr", id_instr, ~mq[0]);
        end else begin
            check("id_pc_idle", id_pc, 32'h0);
            check("id_instr_idle", id_instr, 32'h0);
        end
        acc = exp_req && !stall;
        pp  = (mq.size() != 0) && rdy && !redir;
        @(posedge clk);
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b0;
        bus_stall      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_pc           = RPC;
        repeat (2) @(negedge clk);
        phase = "reset";
        check("rst_req", im_read_mem, 1'b0);
        check("rst_valid", id_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_addr", im_addr, RPC);
        rst = 1'b0;

        // Streaming with decode always ready
        phase = "stream";
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Decode stalled: fill to DEPTH, then drain back-to-back
        phase = "id_stall";
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (7) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Bus stall for three cycles while decode keeps popping
        phase = "bus_stall";
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, (i >= 3 && i <= 5), 1'b0, 32'h0);

        // Redirect with a full FIFO and an unaligned target
        phase = "redirect";
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h103);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // Redirect held for several cycles
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 32'h200);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Address wrap and steady push+pop at count=2 across pointer wrap
        phase = "wrap";
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (9) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a burst with count=3
        phase = "async_rst";
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_rst_count", fifo_count, 3'd3);
        id_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_req", im_read_mem, 1'b0);
        check("rst_valid", id_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        mq.delete();
        m_pc = RPC;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random mix of all controls
        phase = "random";
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 15) == 0), $urandom());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch front end with a DEPTH-entry prefetch FIFO between the instruction memory port and the IF/ID boundary of the RV32 pipeline. It keeps issuing sequential fetches while decode is stalled (load-hazard stall), absorbs bus_stall, and flushes on a taken jump or branch redirect from EXE. It replaces the single pc register plus IF/ID hold-mux scheme.

Parameters:
XLEN, 32, data/address width in bits
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 0, byte address of the first fetch after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
im_addr  output  XLEN  byte address of current fetch request (= fetch_pc)
im_read_mem  output  1  fetch request valid
im_dataout  input  XLEN  instruction word; valid in the same cycle a request is accepted
bus_stall  input  1  bus not accepting; request not accepted and im_dataout ignored
redirect_valid  input  1  taken jump/branch from EXE
redirect_pc  input  XLEN  redirect target byte address
id_ready  input  1  decode accepts the head entry this cycle
id_valid  output  1  head entry valid
id_instr  output  XLEN  head instruction; 0 when id_valid=0
id_pc  output  XLEN  head pc; 0 when id_valid=0
fifo_count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0. While rst=1: im_read_mem=0, id_valid=0, id_instr=0, id_pc=0, fifo_count=0. Outputs are forced during reset, not only after the clock edge.
- Request: im_read_mem = !rst && !redirect_valid && (count < DEPTH). im_addr = fetch_pc at all times.
- Accept: accept = im_read_mem && !bus_stall. On accept, push {fetch_pc, im_dataout} at wr_ptr and set fetch_pc <= fetch_pc + 4.
- fetch_pc wraps modulo 2^XLEN: 0xFFFFFFFC + 4 = 0.
- Pop: pop = id_valid && id_ready && !redirect_valid. rd_ptr advances.
- Pointers wrap modulo DEPTH.
- Count update: count += accept - pop. Simultaneous push and pop leaves count unchanged. A push never occurs when count=DEPTH. A pop never occurs when count=0.
- Head output: id_valid = (count != 0). id_instr and id_pc show the entry at rd_ptr.
- Latency: an accepted fetch appears on id_* in the next cycle, unless the optional bypass is compiled in.
- Redirect (priority over everything): on redirect_valid=1:
  - next edge sets count=0, rd_ptr=wr_ptr=0, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}
  - no request, push or pop occurs in that cycle
  - first fetch at the target is requested in the following cycle
  - redirect held for N cycles: FIFO stays empty and fetch_pc is reloaded each cycle
- bus_stall=1: no push. fetch_pc is held and pops continue normally. Result: FIFO drains while bus_stall is high.
- id_ready=0: head is held, fetch continues until count=DEPTH, then im_read_mem=0.
- Reset asserted mid-operation clears everything immediately. The first request after reset deassertion goes to RESET_PC.
- No lost or duplicated instructions: the id_pc sequence is strictly +4 between redirects.

Optional Feature:
Macro IF_PREFETCH_BYPASS_EN.
- Defined: when count=0 and accept=1, id_valid=1 combinationally in the same cycle, with id_instr=im_dataout and id_pc=fetch_pc.
  - If id_ready=1 that cycle, the word is consumed and not written to the FIFO (count stays 0).
  - If id_ready=0, the word is pushed normally.
  - Zero-cycle fetch-to-decode latency. Combinational path im_dataout -> id_instr.
- Not defined: no bypass. id_* are driven only from FIFO storage. Minimum latency is 1 cycle.

Test Plan:
1. Reset release, id_ready=1, bus_stall=0, memory returns word = address: im_addr sequence 0,4,8,12. id_pc 0,4,8 from cycle 1 (cycle 0 with bypass). fifo_count stays <= 1.
2. id_ready=0 for 10 cycles, DEPTH=4: exactly 4 accepts, then im_read_mem=0 and fifo_count=4. Release: id_pc 0,4,8,12,16 in consecutive cycles with no gap.
3. bus_stall=1 for cycles 3-5, id_ready=1: im_addr held at 12 and no push. FIFO drains to count=0 and id_valid=0. Fetch resumes at 12 with no duplicate id_pc.
4. FIFO full (count=4), redirect_valid=1 with redirect_pc=0x103: next cycle count=0 and im_addr=0x100. Next id_pc=0x100; old entries are never presented.
5. Wrap: RESET_PC=0xFFFFFFF8: fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Simultaneous push and pop at count=2 keeps fifo_count=2 across pointer wrap at DEPTH.
6. Assert rst asynchronously mid-burst with count=3: im_read_mem, id_valid and fifo_count go to 0 before the next edge. After release, first im_addr=RESET_PC.
